// File: rtl/bus_arbiter_4.sv
// Purpose : four-way round-robin bus arbiter with a hold limit and a shared 16-bit data mux.
// Latency : one clk from a request on the arbitration edge to grant/sel/busy; value follows sel/busy combinationally.
// Backpressure: none; the owner keeps the bus while its req stays high, up to HOLD_MAX cycles when others are waiting.
//
// Ports:
//   clk, reset      - rising-edge clock, synchronous active-high reset
//   req[3:0]        - level-sensitive request lines, bit i = requester i
//   A0..A3[15:0]    - data words offered by requesters 0..3
//   grant[3:0]      - registered one-hot grant, zero when idle
//   sel[1:0]        - registered owner index; holds its value through idle periods
//   busy            - registered, high exactly when grant is non-zero
//   value[15:0]     - A[sel] while busy, 16'h0000 otherwise
module bus_arbiter_4 #(
    parameter int HOLD_MAX = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  req,
    input  logic [15:0] A0,
    input  logic [15:0] A1,
    input  logic [15:0] A2,
    input  logic [15:0] A3,
    output logic [3:0]  grant,
    output logic [1:0]  sel,
    output logic        busy,
    output logic [15:0] value
);

    typedef enum logic {IDLE = 1'b0, OWNED = 1'b1} state_t;

    localparam logic [7:0] HCNT_LAST = 8'(HOLD_MAX - 1);

    state_t      state_q, state_d;
    logic [3:0]  grant_q, grant_d;
    logic [1:0]  sel_q, sel_d;
    logic        busy_q, busy_d;
    logic [1:0]  last_q, last_d;
    logic [7:0]  hcnt_q, hcnt_d;

    logic [3:0]  others;
    logic [1:0]  win_all;
    logic [1:0]  win_oth;

    // First set bit of r scanning last+1, last+2, last+3, last (mod 4).
    // The result is only meaningful when r is non-zero.
    function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] l);
        logic [1:0] idx;
        logic       found;
        rr_pick = 2'd0;
        found   = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            idx = l + 2'(k);
            if (!found && r[idx]) begin
                rr_pick = idx;
                found   = 1'b1;
            end
        end
    endfunction

    // grant_q is the owner's one-hot, so masking with it excludes the owner
    // from the candidates; when idle it masks nothing.
    assign others  = req & ~grant_q;
    assign win_all = rr_pick(req, last_q);
    assign win_oth = rr_pick(others, last_q);

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        sel_d   = sel_q;
        busy_d  = busy_q;
        last_d  = last_q;
        hcnt_d  = hcnt_q;
        unique case (state_q)
            IDLE: begin
                if (|req) begin
                    state_d = OWNED;
                    grant_d = 4'b0001 << win_all;
                    sel_d   = win_all;
                    busy_d  = 1'b1;
                    last_d  = win_all;
                    hcnt_d  = 8'd0;
                end
            end
            OWNED: begin
                if (req[sel_q] && hcnt_q < HCNT_LAST) begin
                    hcnt_d = hcnt_q + 8'd1;
                end else if (|others) begin
                    // Either the hold limit expired with someone waiting,
                    // or the owner dropped: hand straight over, no idle gap.
                    grant_d = 4'b0001 << win_oth;
                    sel_d   = win_oth;
                    last_d  = win_oth;
                    hcnt_d  = 8'd0;
                end else if (!req[sel_q]) begin
                    state_d = IDLE;
                    grant_d = 4'b0000;
                    busy_d  = 1'b0;
                end
                // Otherwise the owner keeps the bus and hcnt stays saturated.
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            grant_q <= 4'b0000;
            sel_q   <= 2'b00;
            busy_q  <= 1'b0;
            last_q  <= 2'b11;
            hcnt_q  <= 8'd0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            sel_q   <= sel_d;
            busy_q  <= busy_d;
            last_q  <= last_d;
            hcnt_q  <= hcnt_d;
        end
    end

    assign grant = grant_q;
    assign sel   = sel_q;
    assign busy  = busy_q;

    always_comb begin
        value = 16'h0000;
        if (busy_q) begin
            unique case (sel_q)
                2'd0: value = A0;
                2'd1: value = A1;
                2'd2: value = A2;
                2'd3: value = A3;
                default: value = 16'h0000;
            endcase
        end
    end

endmodule

// File: doc/bus_arbiter_4.md
BUS_ARBITER_4 -- requirements
Module: bus_arbiter_4

Interface
REQ-001 Parameter: HOLD_MAX, default 8, meaning the maximum consecutive grant cycles before forced hand-off when another requester is pending. Legal range is 2..255.
REQ-002 Port: clk  input  1  system clock; all state updates on its rising edge.
REQ-003 Port: reset  input  1  synchronous, active-high reset, sampled on rising clk.
REQ-004 Port: req  input  4  request lines; bit i belongs to requester i; level-sensitive.
REQ-005 Port: A0, A1, A2, A3  input  16 each  data words offered by requesters 0..3.
REQ-006 Port: grant  output  4  one-hot grant, registered; all-zero when idle.
REQ-007 Port: sel  output  2  registered index of the current owner; drives the shared 4:1 16-bit mux select.
REQ-008 Port: busy  output  1  registered; high exactly when grant is non-zero.
REQ-009 Port: value  output  16  shared bus data: A[sel] when busy is high, 16'h0000 otherwise; combinational from the registered sel and busy.

Function
REQ-010 The FSM SHALL have two states: IDLE (no owner) and OWNED (one owner).
REQ-011 Internal state SHALL be: last (2-bit round-robin pointer) and hcnt (8-bit hold counter).
REQ-012 Priority order SHALL be last+1, last+2, last+3, last, all mod 4. The first requester in that order with req set is the winner.
REQ-013 IDLE with req non-zero: next edge -> OWNED; grant = onehot(winner); sel = winner; last = winner; hcnt = 0. Latency from req to grant is 1 cycle.
REQ-014 IDLE with req == 0: remain IDLE; outputs unchanged (zero).
REQ-015 OWNED, owner req still high, and hcnt < HOLD_MAX-1: keep the owner; hcnt increments by 1.
REQ-016 OWNED, owner req still high, hcnt == HOLD_MAX-1, and another req bit set: preempt. On the next edge, grant moves to the winner among the other requesters (the owner is excluded); last = new owner; hcnt = 0.
REQ-017 OWNED, owner req still high, hcnt == HOLD_MAX-1, and no other req: keep the owner; hcnt saturates at HOLD_MAX-1.
REQ-018 OWNED, owner req drops, and other req bits set: direct hand-off on the next edge with no idle cycle. New owner = winner; hcnt = 0.
REQ-019 OWNED, owner req drops, and no other req: next edge -> IDLE; grant = 0; busy = 0; sel holds its last value.
REQ-020 The owner's req is sampled every cycle. A req pulse on a non-owner is only seen if it is high on the arbitration edge; the block SHALL NOT latch requests.
REQ-021 grant SHALL never have more than one bit set, and SHALL never select a requester whose req was low on the arbitration edge.
REQ-022 busy SHALL equal the OR of the grant bits in every cycle.
REQ-023 The sel-to-value mapping SHALL be: 0->A0, 1->A1, 2->A2, 3->A3.

Reset
REQ-024 While reset is high on a clk edge, the block SHALL set:
- state = IDLE
- grant = 4'b0000
- sel = 2'b00
- busy = 0
- hcnt = 0
- last = 2'b11, so requester 0 has top priority after reset
REQ-025 Reset SHALL override all other behaviour, including mid-grant. The grant drops on the reset edge with no hand-off.
REQ-026 Arbitration SHALL resume on the first edge with reset low.

Verification
REQ-027 Reset, then req=4'b1111 held -> one edge later: grant=4'b0001, sel=0, busy=1.
REQ-028 Owner 0 drops req while req[3:1]=3'b111 -> next edge: grant=4'b0010, busy stays 1 with no idle cycle.
REQ-029 HOLD_MAX=8, req=4'b0011 held constant from reset -> grant=4'b0001 for exactly 8 cycles, then 4'b0010 for 8 cycles, then 4'b0001.
REQ-030 Only req=4'b0100 held for 20 cycles -> grant=4'b0100 on every cycle after the first; no preemption; hcnt saturates at 7.
REQ-031 A2=16'hBEEF with grant=4'b0100 -> value=16'hBEEF. All req low -> next edge busy=0 and value=16'h0000.
REQ-032 Reset pulsed while grant=4'b1000 -> next edge: grant=0, busy=0, value=16'h0000. Then reset low with req=4'b1111 -> grant=4'b0001.
